smg_scan_controller: RTL and testbench

- Time-multiplexing sequencer for the 6-digit seven-segment display.
- Generates the one-hot digit-select state consumed by smg_control_module (cur_state) and a frame-stable snapshot of the 24-bit BCD value (Number_Sig).
- Drives the active-low digit enables, aligned to the registered Number_Data, with anti-ghosting dead time, per-digit blink and leading-zero blanking.

---
 rtl/smg_pkg.sv | 23 ++
 rtl/smg_scan_controller_if.sv | 26 ++
 rtl/smg_blink_gen.sv | 47 ++++
 rtl/smg_scan_controller.sv | 118 +++++++++++
 tb/tb_smg_scan_controller.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment display path.
// Holds the one-hot digit-select codes used by both the scan controller and
// smg_control_module, plus digit geometry and a rotate helper.
package smg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;

    typedef logic [NUM_DIGITS-1:0] digit_sel_t;

    // One-hot digit selects; IDLE selects the leftmost digit.
    localparam digit_sel_t IDLE = 6'b000001;
    localparam digit_sel_t ST1  = 6'b000010;
    localparam digit_sel_t ST2  = 6'b000100;
    localparam digit_sel_t ST3  = 6'b001000;
    localparam digit_sel_t ST4  = 6'b010000;
    localparam digit_sel_t ST5  = 6'b100000;

    function automatic digit_sel_t rotl_sel(input digit_sel_t s);
        return {s[NUM_DIGITS-2:0], s[NUM_DIGITS-1]};
    endfunction

endpackage

// File: rtl/smg_scan_controller_if.sv
// Display-scan bus between the scan controller and its environment.
// Inputs to the controller: en, Number_In, blink_mask, lz_blank.
// Outputs from the controller: cur_state, Number_Sig, Scan_Sig, frame_start.
interface smg_scan_controller_if;
    import smg_pkg::*;

    logic                          en;
    logic [NUM_DIGITS*DIGIT_W-1:0] Number_In;
    logic [NUM_DIGITS-1:0]         blink_mask;
    logic                          lz_blank;
    digit_sel_t                    cur_state;
    logic [NUM_DIGITS*DIGIT_W-1:0] Number_Sig;
    logic [NUM_DIGITS-1:0]         Scan_Sig;
    logic                          frame_start;

    modport master (
        output en, Number_In, blink_mask, lz_blank,
        input  cur_state, Number_Sig, Scan_Sig, frame_start
    );

    modport slave (
        input  en, Number_In, blink_mask, lz_blank,
        output cur_state, Number_Sig, Scan_Sig, frame_start
    );

endinterface

// File: rtl/smg_blink_gen.sv
// Blink phase generator.
// Counts frame starts and toggles blink_phase_o once every BLINK_FRAMES
// frames. Ports: clk, rst (sync, active high), en_i, frame_start_i (pulse on
// the edge a frame begins), blink_phase_o.
module smg_blink_gen #(
    parameter int unsigned BLINK_FRAMES = 80
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic frame_start_i,
    output logic blink_phase_o
);

    localparam int unsigned CntW = $clog2(BLINK_FRAMES + 1);

    logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
    logic            phase_q, phase_d;

    // The counter holds the number of frames begun in the current half-period,
    // so the frame start that finds it full opens the next half-period.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (en_i && frame_start_i) begin
            if (frame_cnt_q == CntW'(BLINK_FRAMES)) begin
                frame_cnt_d = CntW'(1);
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_phase_o = phase_q;

endmodule

// File: rtl/smg_scan_controller.sv
// Six-digit seven-segment scan sequencer.
// Rotates a one-hot digit select every SCAN_DIV enabled clocks, snapshots the
// BCD value once per frame and drives registered active-low digit enables
// with dead time, blinking and leading-zero blanking.
// Ports: clk, rst (sync, active high), bus (slave: en, Number_In, blink_mask,
// lz_blank in; cur_state, Number_Sig, Scan_Sig, frame_start out).
module smg_scan_controller
    import smg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEAD_CYC     = 16,
    parameter int unsigned BLINK_FRAMES = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    smg_scan_controller_if.slave  bus
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned NumW = NUM_DIGITS * DIGIT_W;

    logic [CntW-1:0]       cnt_q, cnt_d;
    digit_sel_t            cur_state_q, cur_state_d;
    logic [NumW-1:0]       number_sig_q, number_sig_d;
    logic                  load_q, load_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0] scan_sig_q, scan_sig_d;

    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_all_zero;
    logic [NUM_DIGITS-1:0] off_mask;

    always_comb begin
        cnt_d         = cnt_q;
        cur_state_d   = cur_state_q;
        number_sig_d  = number_sig_q;
        load_d        = load_q;
        frame_start_d = 1'b0;
        if (bus.en) begin
            // First enabled cycle after reset opens a frame without waiting
            // for a full rotation.
            if (load_q) begin
                number_sig_d  = bus.Number_In;
                frame_start_d = 1'b1;
                load_d        = 1'b0;
            end
            if (cnt_q == CntW'(SCAN_DIV - 1)) begin
                cnt_d       = '0;
                cur_state_d = rotl_sel(cur_state_q);
                if (cur_state_q == ST5) begin
                    number_sig_d  = bus.Number_In;
                    frame_start_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Digit k is a leading zero when it and every digit to its left are zero;
    // the rightmost digit always shows.
    always_comb begin
        lz_mask     = '0;
        lz_all_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            lz_all_zero = lz_all_zero &
                (number_sig_q[(NUM_DIGITS - 1 - k) * DIGIT_W +: DIGIT_W] == '0);
            lz_mask[k]  = lz_all_zero;
        end
    end

    assign off_mask = (bus.lz_blank ? lz_mask : '0) |
                      (bus.blink_mask & {NUM_DIGITS{blink_phase}});

    // Registered one clock behind cur_state so the enable lines up with the
    // segment data register downstream.
    always_comb begin
        scan_sig_d = '1;
        if (bus.en && (cnt_q >= CntW'(DEAD_CYC)) && ((cur_state_q & off_mask) == '0)) begin
            scan_sig_d = ~cur_state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            cur_state_q   <= IDLE;
            number_sig_q  <= '0;
            load_q        <= 1'b1;
            frame_start_q <= 1'b0;
            scan_sig_q    <= '1;
        end else begin
            cnt_q         <= cnt_d;
            cur_state_q   <= cur_state_d;
            number_sig_q  <= number_sig_d;
            load_q        <= load_d;
            frame_start_q <= frame_start_d;
            scan_sig_q    <= scan_sig_d;
        end
    end

    smg_blink_gen #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_gen (
        .clk           (clk),
        .rst           (rst),
        .en_i          (bus.en),
        .frame_start_i (frame_start_d),
        .blink_phase_o (blink_phase)
    );

    assign bus.cur_state   = cur_state_q;
    assign bus.Number_Sig  = number_sig_q;
    assign bus.Scan_Sig    = scan_sig_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_smg_scan_controller.sv
module tb_smg_scan_controller;

    localparam int SD = 8;        // clocks per digit
    localparam int DC = 2;        // dead clocks
    localparam int BF = 2;        // frames per blink half-period
    localparam int FR = SD * 6;   // clocks per frame

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smg_scan_controller_if bus ();

    smg_scan_controller #(
        .SCAN_DIV     (SD),
        .DEAD_CYC     (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: everything follows from mk, the number of enabled edges since reset.
    int          mk = 0;
    logic [23:0] m_num = '0;
    logic [5:0]  m_cur = 6'b000001;
    logic [5:0]  m_scan = 6'h3f;
    logic        m_fs = 1'b0;
    int          m_d, m_c, m_ph;
    bit          m_off;

    always @(posedge clk) begin
        if (rst) begin
            mk = 0; m_num = '0; m_cur = 6'b000001; m_scan = 6'h3f; m_fs = 1'b0;
        end else begin
            m_scan = 6'h3f;
            m_fs   = 1'b0;
            if (bus.en) begin
                m_d   = (mk / SD) % 6;
                m_c   = mk % SD;
                m_ph  = ((mk / FR) / BF) % 2;
                m_off = (bus.blink_mask[m_d] && m_ph == 1) ||
                        (bus.lz_blank && m_d < 5 && ((m_num >> (20 - 4 * m_d)) == 0));
                if (m_c >= DC && !m_off) m_scan = ~(6'b000001 << m_d);
                mk++;
                if (mk == 1 || mk % FR == 0) begin
                    m_num = bus.Number_In;
                    m_fs  = 1'b1;
                end
            end
            m_cur = 6'b000001 << ((mk / SD) % 6);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cur_state", 32'(bus.cur_state), 32'(m_cur));
            chk("Number_Sig", 32'(bus.Number_Sig), 32'(m_num));
            chk("Scan_Sig", 32'(bus.Scan_Sig), 32'(m_scan));
            chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
            chk("scan_at_most_one_low", 32'($countones(~bus.Scan_Sig) <= 1), 32'd1);
        end
    end

    task automatic wait_k(input int target);
        int guard = 0;
        while (mk < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_k", 32'(mk), 32'(target));
    endtask

    task automatic frame_acc(output logic [5:0] acc);
        acc = '0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            acc = acc | ~bus.Scan_Sig;
        end
    endtask

    logic [5:0] acc;
    logic [5:0] blink_exp [4];

    initial begin
        blink_exp[0] = 6'h3f; blink_exp[1] = 6'h3f;
        blink_exp[2] = 6'h1f; blink_exp[3] = 6'h1f;
        rst = 1'b1;
        bus.en = 1'b0; bus.Number_In = '0; bus.blink_mask = '0; bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_cur", 32'(bus.cur_state), 32'h01);
        chk("rst_scan", 32'(bus.Scan_Sig), 32'h3f);
        chk("rst_num", 32'(bus.Number_Sig), 32'h0);
        chk("rst_fs", 32'(bus.frame_start), 32'h0);

        // Scan sequence
        rst = 1'b0; bus.en = 1'b1; bus.Number_In = 24'h123456;
        @(negedge clk);
        chk("load_fs", 32'(bus.frame_start), 32'h1);
        chk("load_num", 32'(bus.Number_Sig), 32'h123456);
        wait_k(9);
        chk("step_cur", 32'(bus.cur_state), 32'h02);
        wait_k(11);
        chk("first_lit", 32'(bus.Scan_Sig), 32'h3d);

        // Mid-frame change is held until the wrap
        wait_k(20);
        bus.Number_In = 24'h654321;
        chk("hold_num", 32'(bus.Number_Sig), 32'h123456);
        wait_k(47);
        chk("hold_num_end", 32'(bus.Number_Sig), 32'h123456);
        wait_k(48);
        chk("wrap_num", 32'(bus.Number_Sig), 32'h654321);
        chk("wrap_fs", 32'(bus.frame_start), 32'h1);

        // Leading-zero blanking
        bus.lz_blank = 1'b1; bus.Number_In = 24'h000507;
        wait_k(96);
        bus.Number_In = 24'h000000;
        frame_acc(acc);
        chk("lz_000507", 32'(acc), 32'h38);
        frame_acc(acc);
        chk("lz_000000", 32'(acc), 32'h20);

        // Blink on digit 5
        bus.lz_blank = 1'b0; bus.blink_mask = 6'b100000; bus.Number_In = 24'h123456;
        for (int f = 0; f < 4; f++) begin
            frame_acc(acc);
            chk("blink_frame", 32'(acc), 32'(blink_exp[f]));
        end
        bus.blink_mask = '0;

        // Pause at dwell count 5
        wait_k(405);
        chk("pause_cur", 32'(bus.cur_state), 32'h04);
        chk("pause_lit", 32'(bus.Scan_Sig), 32'h3b);
        bus.en = 1'b0;
        @(negedge clk);
        chk("pause_dark", 32'(bus.Scan_Sig), 32'h3f);
        repeat (9) @(negedge clk);
        chk("pause_hold", 32'(bus.cur_state), 32'h04);
        bus.en = 1'b1;
        repeat (2) @(negedge clk);
        chk("resume_cur", 32'(bus.cur_state), 32'h04);
        @(negedge clk);
        chk("resume_next", 32'(bus.cur_state), 32'h08);

        // Reset mid-dwell
        wait_k(412);
        chk("pre_rst_cur", 32'(bus.cur_state), 32'h08);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cur", 32'(bus.cur_state), 32'h01);
        chk("mid_rst_scan", 32'(bus.Scan_Sig), 32'h3f);
        chk("mid_rst_num", 32'(bus.Number_Sig), 32'h0);
        chk("mid_rst_fs", 32'(bus.frame_start), 32'h0);
        rst = 1'b0; bus.Number_In = 24'h987654;
        @(negedge clk);
        chk("reload_fs", 32'(bus.frame_start), 32'h1);
        chk("reload_num", 32'(bus.Number_Sig), 32'h987654);
        wait_k(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
